// File: rtl/qoa_slice_unpacker.sv
// QOA slice unpacker: collects 8-byte big-endian slices and emits the 4-bit
// scalefactor with 20 3-bit residual codes, one per valid/ready handshake.
module qoa_slice_unpacker #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    input  logic               flush,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_sf,
    output logic [2:0]         res_code,
    output logic [4:0]         res_index,
    output logic               res_last,
    output logic [COUNT_W-1:0] slice_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_r,      state_s;
    logic [63:0]        coll_reg_r,   coll_reg_s;
    logic [3:0]         coll_cnt_r,   coll_cnt_s;
    logic [59:0]        emit_reg_r,   emit_reg_s;
    logic [3:0]         res_sf_r,     res_sf_s;
    logic [4:0]         res_index_r,  res_index_s;
    logic               res_last_r,   res_last_s;
    logic [COUNT_W-1:0] slice_cnt_r,  slice_cnt_s;
    logic               byte_ready_r, byte_ready_s;

    logic full_s;
    logic hs_s;
    logic xfer_s;

    assign full_s = (coll_cnt_r == 4'd8);
    assign hs_s   = (state_r == ST_DRAIN) && res_ready;
    // A full collector hands over either into an idle emitter or on its final handshake.
    assign xfer_s = full_s && ((state_r == ST_IDLE) || (hs_s && res_last_r));

    assign byte_ready = byte_ready_r;
    assign res_valid  = (state_r == ST_DRAIN);
    assign res_sf     = res_sf_r;
    assign res_code   = emit_reg_r[59:57];
    assign res_index  = res_index_r;
    assign res_last   = res_last_r;
    assign slice_cnt  = slice_cnt_r;

    // Next-state and output computation for collector and emitter.
    always_comb begin
        state_s     = state_r;
        coll_reg_s  = coll_reg_r;
        coll_cnt_s  = coll_cnt_r;
        emit_reg_s  = emit_reg_r;
        res_sf_s    = res_sf_r;
        res_index_s = res_index_r;
        res_last_s  = res_last_r;
        slice_cnt_s = slice_cnt_r;

        if (flush) begin
            coll_cnt_s  = 4'd0;
            state_s     = ST_IDLE;
            res_index_s = 5'd0;
            res_last_s  = 1'b0;
        end else begin
            if (byte_valid && byte_ready_r) begin
                coll_reg_s = {coll_reg_r[55:0], byte_data};
                coll_cnt_s = coll_cnt_r + 4'd1;
            end else begin
                coll_reg_s = coll_reg_r;
                coll_cnt_s = coll_cnt_r;
            end

            if (hs_s) begin
                emit_reg_s  = {emit_reg_r[56:0], 3'b000};
                res_index_s = res_index_r + 5'd1;
                res_last_s  = (res_index_r == 5'd18);
                if (res_last_r) begin
                    slice_cnt_s = slice_cnt_r + CNT_ONE;
                    state_s     = ST_IDLE;
                end else begin
                    slice_cnt_s = slice_cnt_r;
                    state_s     = state_r;
                end
            end else begin
                emit_reg_s  = emit_reg_r;
                res_index_s = res_index_r;
            end

            // Transfer overrides the handshake's return to idle so draining has no bubble.
            if (xfer_s) begin
                res_sf_s    = coll_reg_r[63:60];
                emit_reg_s  = coll_reg_r[59:0];
                res_index_s = 5'd0;
                res_last_s  = 1'b0;
                coll_cnt_s  = 4'd0;
                state_s     = ST_DRAIN;
            end else begin
                res_sf_s = res_sf_r;
            end
        end

        byte_ready_s = (coll_cnt_s != 4'd8);
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            coll_reg_r   <= 64'd0;
            coll_cnt_r   <= 4'd0;
            emit_reg_r   <= 60'd0;
            res_sf_r     <= 4'd0;
            res_index_r  <= 5'd0;
            res_last_r   <= 1'b0;
            slice_cnt_r  <= {COUNT_W{1'b0}};
            byte_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            coll_reg_r   <= coll_reg_s;
            coll_cnt_r   <= coll_cnt_s;
            emit_reg_r   <= emit_reg_s;
            res_sf_r     <= res_sf_s;
            res_index_r  <= res_index_s;
            res_last_r   <= res_last_s;
            slice_cnt_r  <= slice_cnt_s;
            byte_ready_r <= byte_ready_s;
        end
    end

endmodule

// File: tb/tb_qoa_slice_unpacker.sv
// Directed self-checking bench for qoa_slice_unpacker; a second instance with a
// 2-bit counter shares the stimulus to observe slice_cnt wrap.
module tb_qoa_slice_unpacker;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        flush;
    logic        res_ready;

    logic        byte_ready;
    logic        res_valid;
    logic [3:0]  res_sf;
    logic [2:0]  res_code;
    logic [4:0]  res_index;
    logic        res_last;
    logic [15:0] slice_cnt;

    logic        byte_ready2;
    logic        res_valid2;
    logic [3:0]  res_sf2;
    logic [2:0]  res_code2;
    logic [4:0]  res_index2;
    logic        res_last2;
    logic [1:0]  slice_cnt2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_n   = 0;
    int br_low = 0;

    logic [2:0] hs_code  [0:511];
    logic [3:0] hs_sf    [0:511];
    logic [4:0] hs_idx   [0:511];
    logic       hs_last  [0:511];
    int         hs_cycle [0:511];

    qoa_slice_unpacker #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .flush(flush), .res_valid(res_valid),
        .res_ready(res_ready), .res_sf(res_sf), .res_code(res_code),
        .res_index(res_index), .res_last(res_last), .slice_cnt(slice_cnt)
    );

    qoa_slice_unpacker #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready2), .flush(flush), .res_valid(res_valid2),
        .res_ready(res_ready), .res_sf(res_sf2), .res_code(res_code2),
        .res_index(res_index2), .res_last(res_last2), .slice_cnt(slice_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake log and byte_ready-low counter, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready && hs_n < 512) begin
            hs_code[hs_n]  <= res_code;
            hs_sf[hs_n]    <= res_sf;
            hs_idx[hs_n]   <= res_index;
            hs_last[hs_n]  <= res_last;
            hs_cycle[hs_n] <= cyc;
            hs_n           <= hs_n + 1;
        end
        if (rst_n && !byte_ready) br_low <= br_low + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_slice(input logic [63:0] s);
        for (int i = 0; i < 8; i++) send_byte(s[63-8*i -: 8]);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (int'(slice_cnt) != target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("slice_cnt_wait", 64'(slice_cnt), 64'(target));
    endtask

    logic [63:0] slice1;
    logic [63:0] slice2;
    logic [59:0] t1_codes;
    int base;
    int br0;
    int n;

    initial begin
        slice1   = 64'hF123_4567_89AB_CDEF;
        slice2   = 64'h1000_0000_0000_0000;
        t1_codes = {3'd0, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd6, 3'd3, 3'd6,
                    3'd1, 3'd1, 3'd5, 3'd2, 3'd7, 3'd4, 3'd6, 3'd7, 3'd5, 3'd7};
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        flush      = 1'b0;
        res_ready  = 1'b1;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {52'd0, res_valid, res_sf, res_code, res_index, res_last},
              64'd0);
        check("reset_slice_cnt", 64'(slice_cnt), 64'd0);
        check("reset_byte_ready", {63'd0, byte_ready}, 64'd1);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: one slice, consumer always ready
        base = hs_n;
        send_slice(slice1);
        wait_cnt(1);
        check("t1_hs_count", 64'(hs_n - base), 64'd20);
        for (int i = 0; i < 20; i++) begin
            check("t1_sf", 64'(hs_sf[base+i]), 64'hF);
            check("t1_code", 64'(hs_code[base+i]), 64'(t1_codes[59-3*i -: 3]));
            check("t1_index", 64'(hs_idx[base+i]), 64'(i));
            check("t1_last", 64'(hs_last[base+i]), (i == 19) ? 64'd1 : 64'd0);
        end
        check("t1_valid_after", {63'd0, res_valid}, 64'd0);

        // Test 2: stalled consumer, latency and hold
        res_ready = 1'b0;
        base = hs_n;
        send_slice(slice2);
        check("t2_latency_pre", {63'd0, res_valid}, 64'd0);
        @(posedge clk); #1;
        check("t2_latency_post", {63'd0, res_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t2_hold", {50'd0, res_valid, res_sf, res_code, res_index, res_last},
                  {50'd0, 1'b1, 4'h1, 3'd0, 5'd0, 1'b0});
        end
        res_ready = 1'b1;
        wait_cnt(2);
        check("t2_hs_count", 64'(hs_n - base), 64'd20);
        check("t2_code19", 64'(hs_code[base+19]), 64'd0);
        check("t2_last19", 64'(hs_last[base+19]), 64'd1);

        // Test 3: two slices back to back without a bubble
        base = hs_n;
        br0  = br_low;
        send_slice(slice1);
        send_slice(slice2);
        wait_cnt(4);
        check("t3_hs_count", 64'(hs_n - base), 64'd40);
        check("t3_no_gap", 64'(hs_cycle[base+39] - hs_cycle[base]), 64'd39);
        check("t3_last20", 64'(hs_last[base+19]), 64'd1);
        check("t3_last40", 64'(hs_last[base+39]), 64'd1);
        check("t3_last_mid", 64'(hs_last[base+20]), 64'd0);
        check("t3_idx_restart", 64'(hs_idx[base+20]), 64'd0);
        check("t3_sf_second", 64'(hs_sf[base+20]), 64'h1);
        check("t3_code1", 64'(hs_code[base+1]), 64'd4);
        check("t3_br_low", {63'd0, (br_low - br0) > 0}, 64'd1);

        // Test 4: flush discards a partial slice
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        base = hs_n;
        send_slice(slice1);
        wait_cnt(5);
        check("t4_hs_count", 64'(hs_n - base), 64'd20);
        for (int i = 0; i < 20; i++) begin
            check("t4_code", 64'(hs_code[base+i]), 64'(t1_codes[59-3*i -: 3]));
        end
        check("t4_sf", 64'(hs_sf[base]), 64'hF);
        check("t4_cnt2", 64'(slice_cnt2), 64'd1);

        // Test 5: asynchronous reset mid-drain
        fork
            send_slice(slice1);
        join_none
        n = 0;
        while (res_index != 5'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reach_idx7", 64'(res_index), 64'd7);
        disable fork;
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", {63'd0, res_valid}, 64'd0);
        check("t5_index", 64'(res_index), 64'd0);
        check("t5_slice_cnt", 64'(slice_cnt), 64'd0);
        check("t5_byte_ready", {63'd0, byte_ready}, 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 6: five slices after reset, 2-bit counter wraps to 1
        base = hs_n;
        for (int s = 0; s < 5; s++) send_slice(slice2);
        wait_cnt(5);
        check("t6_hs_count", 64'(hs_n - base), 64'd100);
        check("t6_first_sf", 64'(hs_sf[base]), 64'h1);
        check("t6_first_idx", 64'(hs_idx[base]), 64'd0);
        check("t6_wrap", 64'(slice_cnt2), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
